mult_unit: RTL and testbench
============================

Name: mult_unit

Overview:
- Iterative 32x32 shift-add multiplier for the Mini_MIPS datapath. Executes mult, multu, madd and maddu.
- Acts as the writer for the register file's hi/lo write port. On completion it drives write_enable, mul, write_data_1 (lo) and write_data_2 (hi) for exactly one cycle.
- For madd/maddu, the register file performs the {hi,lo} accumulate; this unit supplies only the 64-bit product and mul=2.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; accepted only in IDLE.
- op  input  2  0=mult, 1=multu, 2=madd, 3=maddu; sampled on accept.
- operand_a  input  WIDTH  rs value; sampled on accept.
- operand_b  input  WIDTH  rt value; sampled on accept.
- flush  input  1  pipeline kill; aborts any in-flight operation.
- busy  output  1  high in BUSY and WB; the pipeline stalls hi/lo consumers on it.
- write_enable  output  1  one-cycle writeback strobe to the register file.
- mul  output  2  1=overwrite {hi,lo}; 2=accumulate into {hi,lo}; 0 when write_enable is low.
- write_data_1  output  WIDTH  product[WIDTH-1:0] (lo).
- write_data_2  output  WIDTH  product[2*WIDTH-1:WIDTH] (hi).

Behaviour:
- States: IDLE, BUSY, WB.
- Reset (rst=1 at posedge), from any state:
  - state=IDLE, counter=0, accumulator=0, result registers=0.
  - All outputs 0 the following cycle.
  - Mid-operation reset discards the operation; no write is issued.
- Accept: start=1, state=IDLE, flush=0 at posedge T.
  - Latch op[1] as is_madd.
  - Signed ops (op[0]=0): latch |operand_a| and |operand_b| as WIDTH-bit unsigned magnitudes (0x80000000 -> 0x80000000); neg = a[31]^b[31].
  - Unsigned ops: latch operands raw; neg=0.
  - Clear accumulator and counter; go to BUSY.
- BUSY, one iteration per cycle, counter 0..WIDTH-1:
  - If multiplier LSB=1, add multiplicand into the upper half of the 2*WIDTH accumulator.
  - Shift accumulator/multiplier right by 1 (standard shift-add; carry out of the add preserved in bit 2*WIDTH).
  - On counter=WIDTH-1: register result = neg ? (~acc_final+1) : acc_final (2*WIDTH bits); go to WB.
- WB, exactly one cycle:
  - write_enable = !flush.
  - mul = is_madd ? 2 : 1, gated by write_enable.
  - write_data_1/2 = result halves.
  - Next state IDLE.
- Latency: accept at posedge T; busy=1 from T+1 through T+WIDTH+1; write_enable=1 during cycle T+WIDTH+1 (cycle 33 after accept); busy=0 at T+WIDTH+2.
- start while busy=1 is ignored. It is not queued, and operands are not resampled.
- Back-to-back: start may be accepted on the edge that leaves WB (state IDLE that cycle) at the earliest. Max throughput is one op per WIDTH+2 cycles.
- flush:
  - In BUSY: next state IDLE; no write is issued.
  - In WB: write_enable forced 0 combinationally in that cycle.
  - In IDLE: start is ignored (flush wins).
- Zero operand: result 0 regardless of neg (−0 = 0).
- write_data_1/2 hold the last result after WB; they are meaningful only while write_enable=1.
- busy and the state are registered. write_enable and mul are the registered WB decode ANDed with !flush.

Test Plan:
- mult, a=0xFFFFFFFD (−3), b=7 -> at cycle 33 after accept: write_enable=1 for one cycle, mul=1, write_data_2=0xFFFFFFFF, write_data_1=0xFFFFFFEB; busy high cycles 1..33.
- multu, a=b=0xFFFFFFFF -> mul=1, write_data_2=0xFFFFFFFE, write_data_1=0x00000001. Repeat as signed mult -> hi=0x00000000, lo=0x00000001.
- mult, a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. Then maddu 5*6 -> mul=2, hi=0, lo=0x1E.
- Accept mult 3*4; pulse start with a=9,b=9 at cycle 10; assert flush at cycle 20 -> no write_enable; busy=0 at cycle 21; new start at cycle 22 accepted and completes correctly.
- flush coincident with WB cycle -> write_enable=0, mul=0, state IDLE next cycle. rst at cycle 15 of BUSY -> all outputs 0, no write.
- Back-to-back: start held high continuously -> write_enable pulses exactly every 34 cycles, each with the correct product. Random 1000 ops of all four op codes, compared against a reference model with mul code checked.

Source files
------------

// File: rtl/mult_unit.sv
// Iterative 32x32 shift-add multiplier (mult/multu/madd/maddu) driving the
// register file's hi/lo write port for one cycle on completion.
module mult_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  input  logic               flush,
  output logic               busy,
  output logic               write_enable,
  output logic [1:0]         mul,
  output logic [WIDTH-1:0]   write_data_1,
  output logic [WIDTH-1:0]   write_data_2
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_WB
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   result_q;
  logic [2*WIDTH-1:0]   result_d;
  logic [WIDTH-1:0]     mcand_q;
  logic                 neg_q;
  logic                 madd_q;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;

  // Magnitudes of signed operands; 0x80000000 maps to itself as unsigned.
  always_comb begin
    a_mag = operand_a;
    b_mag = operand_b;
    if (!op[0] && operand_a[WIDTH-1]) a_mag = '0 - operand_a;
    if (!op[0] && operand_b[WIDTH-1]) b_mag = '0 - operand_b;
  end

  // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_d    = {sum, acc_q[WIDTH-1:1]};
    result_d = neg_q ? ('0 - acc_d) : acc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      madd_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            madd_q  <= op[1];
            neg_q   <= !op[0] && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            mcand_q <= a_mag;
            acc_q   <= {{WIDTH{1'b0}}, b_mag};
            cnt_q   <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
              result_q <= result_d;
              state_q  <= S_WB;
            end
          end
        end
        S_WB:    state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign write_enable = (state_q == S_WB) && !flush;
  assign mul          = write_enable ? (madd_q ? 2'd2 : 2'd1) : 2'd0;
  assign write_data_1 = result_q[WIDTH-1:0];
  assign write_data_2 = result_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_mult_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        busy;
  logic        write_enable;
  logic [1:0]  mul;
  logic [31:0] write_data_1;
  logic [31:0] write_data_2;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  mult_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .flush        (flush),
    .busy         (busy),
    .write_enable (write_enable),
    .mul          (mul),
    .write_data_1 (write_data_1),
    .write_data_2 (write_data_2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_prod(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa;
    longint sb;
    if (!o[0]) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Issue one op and watch 35 cycles after accept; noise pulses start while busy.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_p,
                        input logic [1:0] exp_mul, input bit noise);
    int we_cyc = 0;
    int we_cnt = 0;
    int busy_cnt = 0;
    logic [63:0] got = '0;
    logic [1:0]  got_mul = '0;
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    for (int n = 1; n <= 35; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (write_enable) begin
        we_cnt++;
        we_cyc  = n;
        got     = {write_data_2, write_data_1};
        got_mul = mul;
      end
      start     = noise && (n < 31) && ($urandom_range(0, 3) == 0);
      op        = 2'($urandom_range(0, 3));
      operand_a = $urandom;
      operand_b = $urandom;
    end
    start = 1'b0;
    chk({tag, "_we_cycle"}, 64'(we_cyc), 64'd33);
    chk({tag, "_we_count"}, 64'(we_cnt), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({tag, "_mul"}, 64'(got_mul), 64'(exp_mul));
    chk({tag, "_product"}, got, exp_p);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ba[4];
    logic [31:0] bb[4];
    logic [1:0]  bo[4];
    logic        seen;
    int          k;
    int          last;

    rst = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_we", 64'(write_enable), 64'd0);
    chk("reset_mul", 64'(mul), 64'd0);
    chk("reset_data", {write_data_2, write_data_1}, 64'd0);

    run_op("mult_neg3x7", 2'd0, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 2'd1, 1'b0);
    run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 2'd1, 1'b0);
    run_op("mult_m1xm1", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 2'd1, 1'b0);
    run_op("mult_minint", 2'd0, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 2'd1, 1'b0);
    run_op("maddu_5x6", 2'd3, 32'd5, 32'd6, 64'd30, 2'd2, 1'b0);
    run_op("madd_neg2x3", 2'd2, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 2'd2, 1'b0);
    run_op("mult_zero", 2'd0, 32'd0, 32'hFFFFFFFB, 64'd0, 2'd1, 1'b0);

    // Flush during BUSY, with an ignored start pulse at cycle 10.
    @(negedge clk);
    start = 1'b1; op = 2'd0; operand_a = 32'd3; operand_b = 32'd4;
    seen = 1'b0;
    for (int n = 1; n <= 21; n++) begin
      @(negedge clk);
      seen  = seen | write_enable;
      start = (n == 10);
      if (n == 10) begin operand_a = 32'd9; operand_b = 32'd9; end
      flush = (n == 20);
      if (n == 21) chk("flush_busy_low", 64'(busy), 64'd0);
    end
    chk("flush_no_write", 64'(seen), 64'd0);
    run_op("after_flush", 2'd0, 32'd7, 32'hFFFFFFF6, 64'hFFFFFFFF_FFFFFFBA, 2'd1, 1'b0);

    // Flush coincident with the WB cycle.
    @(negedge clk);
    start = 1'b1; op = 2'd1; operand_a = 32'd5; operand_b = 32'd5;
    seen = 1'b0;
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n < 33) seen = seen | write_enable;
    end
    flush = 1'b1;
    #1;
    chk("wbflush_busy", 64'(busy), 64'd1);
    chk("wbflush_we", 64'(write_enable), 64'd0);
    chk("wbflush_mul", 64'(mul), 64'd0);
    chk("wbflush_early_we", 64'(seen), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("wbflush_idle", 64'(busy), 64'd0);

    // Reset in the middle of BUSY.
    @(negedge clk);
    start = 1'b1; op = 2'd0; operand_a = 32'd6; operand_b = 32'd7;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_we", 64'(write_enable), 64'd0);
    chk("midrst_mul", 64'(mul), 64'd0);
    chk("midrst_data", {write_data_2, write_data_1}, 64'd0);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen = seen | write_enable | busy;
    end
    chk("midrst_quiet", 64'(seen), 64'd0);

    // Back-to-back with start held high.
    for (int i = 0; i < 4; i++) begin
      bo[i] = 2'($urandom_range(0, 3));
      ba[i] = $urandom;
      bb[i] = $urandom;
    end
    @(negedge clk);
    start = 1'b1; op = bo[0]; operand_a = ba[0]; operand_b = bb[0];
    k = 0; last = 0;
    for (int n = 0; n < 200 && k < 4; n++) begin
      @(negedge clk);
      if (write_enable) begin
        chk("b2b_product", {write_data_2, write_data_1}, ref_prod(bo[k], ba[k], bb[k]));
        chk("b2b_mul", 64'(mul), bo[k][1] ? 64'd2 : 64'd1);
        if (k > 0) chk("b2b_gap", 64'(cyc - last), 64'd34);
        last = cyc;
        k++;
        if (k < 4) begin
          op = bo[k]; operand_a = ba[k]; operand_b = bb[k];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_count", 64'(k), 64'd4);
    repeat (3) @(negedge clk);

    // Randomized ops with start noise while busy.
    for (int i = 0; i < 1000; i++) begin
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'd0;
        1: b = 32'h80000000;
        2: a = 32'hFFFFFFFF;
        default: ;
      endcase
      run_op("rand", o, a, b, ref_prod(o, a, b), o[1] ? 2'd2 : 2'd1, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
